// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/gnt/rvalid data-bus master that registers results into W.
// Build option MEMSTG_MISALIGN_TRAP_EN traps misaligned/illegal accesses instead of forcing natural alignment.
module mem_stage_lsu #(
  parameter int XLEN = 32,
  parameter int NBE  = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            StallM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [NBE-1:0]  dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic            MisalignW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ALU_ResultW,
  output logic [XLEN-1:0] ReadDataW
);
  localparam int OFFW = $clog2(NBE);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            valid_w_q, valid_w_d, regwrite_w_q, regwrite_w_d, misalign_w_q, misalign_w_d;
  logic [1:0]      rsrc_w_q, rsrc_w_d;
  logic [4:0]      rd_w_q, rd_w_d;
  logic [XLEN-1:0] pc4_w_q, pc4_w_d, alu_w_q, alu_w_d, rdata_w_q, rdata_w_d;

  logic            illegal_s, misalign_s, active_s, done_s, stall_s;
  logic [1:0]      size_s;
  logic [OFFW-1:0] amask_s, off_s;
  logic [NBE-1:0]  be_ones_s;
  logic [XLEN-1:0] wdata_rep_s, shifted_s, ext_s;

  // Access-size decode, legality and alignment handling
  always_comb begin
    case (Funct3M)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
      3'b011, 3'b110: illegal_s = (XLEN == 64) ? 1'b0 : 1'b1;
      default: illegal_s = 1'b1;
    endcase
    if (illegal_s) begin
      size_s = (XLEN == 64) ? 2'b11 : 2'b10;
    end else begin
      size_s = Funct3M[1:0];
    end
    case (size_s)
      2'b00:   amask_s = '0;
      2'b01:   amask_s = OFFW'(1);
      2'b10:   amask_s = OFFW'(3);
      default: amask_s = '1;
    endcase
`ifdef MEMSTG_MISALIGN_TRAP_EN
    misalign_s = ValidM & (MemReadM | MemWriteM) & (illegal_s | (|(ALU_ResultM[OFFW-1:0] & amask_s)));
    off_s      = ALU_ResultM[OFFW-1:0];
`else
    misalign_s = 1'b0;
    off_s      = ALU_ResultM[OFFW-1:0] & ~amask_s;
`endif
    // rst gating keeps the bus and stall quiet while reset is held, whatever M presents
    active_s = rst & ValidM & (MemReadM | MemWriteM) & ~misalign_s;
    if (state_q == IDLE) begin
      done_s = active_s & MemWriteM & dmem_gnt;
    end else begin
      done_s = dmem_rvalid;
    end
    stall_s = (active_s & ~done_s) | ((state_q == WAIT) & ~dmem_rvalid);
    StallM  = stall_s;
  end

  // Bus request, byte enables and lane-replicated store data
  always_comb begin
    dmem_req = active_s & (state_q == IDLE);
    dmem_we  = dmem_req & MemWriteM;
    case (size_s)
      2'b00:   be_ones_s = NBE'(1);
      2'b01:   be_ones_s = NBE'(3);
      2'b10:   be_ones_s = NBE'(15);
      default: be_ones_s = '1;
    endcase
    case (size_s)
      2'b00:   wdata_rep_s = {NBE{WriteDataM[7:0]}};
      2'b01:   wdata_rep_s = {(NBE/2){WriteDataM[15:0]}};
      2'b10:   wdata_rep_s = {(NBE/4){WriteDataM[31:0]}};
      default: wdata_rep_s = WriteDataM;
    endcase
    if (dmem_req) begin
      dmem_addr  = {ALU_ResultM[XLEN-1:OFFW], {OFFW{1'b0}}};
      dmem_be    = be_ones_s << off_s;
      dmem_wdata = wdata_rep_s;
    end else begin
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
    end
  end

  // Load-beat extraction using the offset and size captured at grant
  always_comb begin
    shifted_s = dmem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ext_s = XLEN'(shifted_s[7:0])  | ({XLEN{~uns_q & shifted_s[7]}} << 8);
      2'b01:   ext_s = XLEN'(shifted_s[15:0]) | ({XLEN{~uns_q & shifted_s[15]}} << 16);
      2'b10:   ext_s = XLEN'(shifted_s[31:0]) | ({XLEN{~uns_q & shifted_s[31]}} << 32);
      default: ext_s = shifted_s;
    endcase
  end

  // Access FSM and W-stage next-state
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    valid_w_d    = 1'b0;
    regwrite_w_d = 1'b0;
    misalign_w_d = 1'b0;
    rsrc_w_d     = rsrc_w_q;
    rd_w_d       = rd_w_q;
    pc4_w_d      = pc4_w_q;
    alu_w_d      = alu_w_q;
    rdata_w_d    = rdata_w_q;
    case (state_q)
      IDLE: begin
        if (active_s & ~MemWriteM & dmem_gnt) begin
          state_d = WAIT;
          off_d   = off_s;
          size_d  = size_s;
          uns_d   = Funct3M[2];
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!stall_s && ValidM) begin
      valid_w_d    = 1'b1;
      regwrite_w_d = RegWriteM & ~misalign_s;
      misalign_w_d = misalign_s;
      rsrc_w_d     = ResultSrcM;
      rd_w_d       = RD_M;
      pc4_w_d      = PCPlus4M;
      alu_w_d      = ALU_ResultM;
      rdata_w_d    = ext_s;
    end else begin
      valid_w_d = 1'b0;
    end
  end

  // State and W-stage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      valid_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      misalign_w_q <= 1'b0;
      rsrc_w_q     <= 2'b00;
      rd_w_q       <= 5'd0;
      pc4_w_q      <= '0;
      alu_w_q      <= '0;
      rdata_w_q    <= '0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      valid_w_q    <= valid_w_d;
      regwrite_w_q <= regwrite_w_d;
      misalign_w_q <= misalign_w_d;
      rsrc_w_q     <= rsrc_w_d;
      rd_w_q       <= rd_w_d;
      pc4_w_q      <= pc4_w_d;
      alu_w_q      <= alu_w_d;
      rdata_w_q    <= rdata_w_d;
    end
  end

  assign ValidW      = valid_w_q;
  assign RegWriteW   = regwrite_w_q;
  assign MisalignW   = misalign_w_q;
  assign ResultSrcW  = rsrc_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pc4_w_q;
  assign ALU_ResultW = alu_w_q;
  assign ReadDataW   = rdata_w_q;
endmodule
